// File: rtl/seq_mult32_if.sv
// Handshake and result bundle between the control unit (master) and seq_mult32 (slave).
interface seq_mult32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_mult32.sv
// Multi-cycle shift-add multiplier producing a 2*WIDTH product as hi/lo words.
// Optional MULT_EARLY_EXIT_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module seq_mult32 #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  seq_mult32_if.slave  io_bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CntW-1:0]    r_count;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_mplier_shr;
  logic [2*WIDTH-1:0] w_acc_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_calc_last;

  // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
  assign w_a_mag = (io_bus.signed_op && io_bus.a[WIDTH-1]) ? -io_bus.a : io_bus.a;
  assign w_b_mag = (io_bus.signed_op && io_bus.b[WIDTH-1]) ? -io_bus.b : io_bus.b;

  assign w_mplier_shr = r_mplier >> 1;
  assign w_acc_sum    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod       = r_neg ? -r_acc : r_acc;

`ifdef MULT_EARLY_EXIT_EN
  assign w_calc_last = (r_count == CntW'(WIDTH - 1)) || (w_mplier_shr == '0);
`else
  assign w_calc_last = (r_count == CntW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= io_bus.signed_op & (io_bus.a[WIDTH-1] ^ io_bus.b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= StCalc;
          end
        end
        StCalc: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shr;
          r_count  <= r_count + CntW'(1);
          if (w_calc_last) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          {r_hi, r_lo} <= w_prod;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.hi   = r_hi;
  assign io_bus.lo   = r_lo;
endmodule
